serial_adder: RTL

Bit-serial WIDTH-bit adder that adds two operands LSB-first over WIDTH clock cycles and reports a registered sum and carry-out. It directly consumes the sum/carry outputs of `one_bit_half_adder` (two instances form a full adder) and adds a carry flip-flop, shift registers and a start/done handshake around them. It is the sequential stage that turns the single-bit adder into a multi-bit datapath.

---
 rtl/serial_adder_pkg.sv | 8 +
 rtl/one_bit_full_adder.sv | 31 +++
 rtl/one_bit_half_adder.sv | 12 +
 rtl/serial_adder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings.
package serial_adder_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/one_bit_full_adder.sv
// Single-bit full adder assembled from two half adders; the carry-out is
// the OR of both half-adder carries (they can never both be high).
module one_bit_full_adder (
    input  logic i0,
    input  logic i1,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    one_bit_half_adder u_ha0 (
        .i0    (i0),
        .i1    (i1),
        .sum   (ha0_sum),
        .carry (ha0_carry)
    );

    one_bit_half_adder u_ha1 (
        .i0    (ha0_sum),
        .i1    (cin),
        .sum   (sum),
        .carry (ha1_carry)
    );

    assign carry = ha0_carry | ha1_carry;

endmodule

// File: rtl/one_bit_half_adder.sv
// Single-bit half adder: sum is the XOR, carry is the AND of the inputs.
module one_bit_half_adder (
    input  logic i0,
    input  logic i1,
    output logic sum,
    output logic carry
);

    assign sum   = i0 ^ i1;
    assign carry = i0 & i1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted out LSB-first through a
// single full adder, one bit per clock, with a start/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_SHIFT = SHIFT,
        ST_DONE  = DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic             carry_ff;
    logic [CNT_W-1:0] count;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_carry;

    one_bit_full_adder u_fa (
        .i0    (a_reg[0]),
        .i1    (b_reg[0]),
        .cin   (carry_ff),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign last_bit = (count == CNT_W'(WIDTH - 1));

    // Partial sum with the fresh result bit shifted in at the MSB; written so
    // that it also holds for WIDTH=1 where there is nothing below the MSB.
    always_comb begin
        psum_next            = psum >> 1;
        psum_next[WIDTH-1]   = fa_sum;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the current state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, per-bit shifting, and result registration
    // on the edge that processes the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            psum     <= '0;
            carry_ff <= 1'b0;
            count    <= '0;
            sum      <= '0;
            carry    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        psum     <= '0;
                        carry_ff <= 1'b0;
                        count    <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_reg    <= a_reg >> 1;
                    b_reg    <= b_reg >> 1;
                    psum     <= psum_next;
                    carry_ff <= fa_carry;
                    count    <= count + CNT_W'(1);
                    if (last_bit) begin
                        sum   <= psum_next;
                        carry <= fa_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
